// File: rtl/nway_wb_cache_pkg.sv
// nway_wb_cache_pkg: shared state encoding, default geometry and PLRU sizing for nway_wb_cache
package nway_wb_cache_pkg;
    localparam int DEF_S_OFFSET = 5;
    localparam int DEF_S_INDEX  = 3;
    localparam int DEF_N_WAYS   = 4;
    typedef enum logic [1:0] {CHECK_TAG, WRITE_BACK, ALLOCATE} state_t;
    function automatic int plru_bits(input int n_ways);
        return n_ways - 1;
    endfunction
endpackage

// File: rtl/nway_wb_cache_plru_tree.sv
// nway_wb_cache_plru_tree: per-set tree pseudo-LRU
//  clk, reset (async, active-high) ; index: set ; touch/touch_way: mark way recently used ;
//  victim_way: way the tree currently points at for the indexed set
module nway_wb_cache_plru_tree
    import nway_wb_cache_pkg::*;
#(
    parameter int S_INDEX = DEF_S_INDEX,
    parameter int N_WAYS  = DEF_N_WAYS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [S_INDEX-1:0]        index,
    input  logic                      touch,
    input  logic [$clog2(N_WAYS)-1:0] touch_way,
    output logic [$clog2(N_WAYS)-1:0] victim_way
);
    localparam int L = $clog2(N_WAYS);
    localparam int B = plru_bits(N_WAYS);
    logic [B-1:0] tree_q [2**S_INDEX];
    logic [B-1:0] tree, tree_n;
    assign tree = tree_q[index];
    // Heap-numbered nodes (root = 1); a node bit of 1 means the victim lies in the right subtree.
    always_comb begin
        int node, vn;
        node   = 1;
        vn     = 1;
        tree_n = tree;
        for (int l = 0; l < L; l++) begin
            tree_n[node-1] = ~touch_way[L-1-l];
            node = 2*node + int'(touch_way[L-1-l]);
            vn   = 2*vn + int'(tree[vn-1]);
        end
        victim_way = L'(vn - N_WAYS);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2**S_INDEX; s++) tree_q[s] <= '0;
        end else if (touch) begin
            tree_q[index] <= tree_n;
        end
    end
endmodule

// File: rtl/nway_wb_cache.sv
// nway_wb_cache: N-way set-associative write-back, write-allocate cache with tree PLRU and hit/miss stats
//  CPU side : mem_addr, mem_read, mem_write, mem_wdata, mem_byte_enable -> mem_rdata, mem_resp
//  Memory   : pmem_addr, pmem_read, pmem_write, pmem_wdata -> pmem_rdata, pmem_resp (line wide)
//  Stats    : hit_count, miss_count (saturating), count_clear
//  clk, reset (async, active-high)
module nway_wb_cache
    import nway_wb_cache_pkg::*;
#(
    parameter int S_OFFSET = DEF_S_OFFSET,
    parameter int S_INDEX  = DEF_S_INDEX,
    parameter int N_WAYS   = DEF_N_WAYS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 mem_addr,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_byte_enable,
    output logic [31:0]                 mem_rdata,
    output logic                        mem_resp,
    output logic [31:0]                 pmem_addr,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [8*(2**S_OFFSET)-1:0]  pmem_wdata,
    input  logic [8*(2**S_OFFSET)-1:0]  pmem_rdata,
    input  logic                        pmem_resp,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count,
    input  logic                        count_clear
);
    localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
    localparam int S_LINE = 8 * 2**S_OFFSET;
    localparam int SETS   = 2**S_INDEX;
    localparam int WW     = $clog2(N_WAYS);
    state_t state, state_n;
    logic [S_TAG-1:0]  tag_q   [N_WAYS][SETS];
    logic              valid_q [N_WAYS][SETS];
    logic              dirty_q [N_WAYS][SETS];
    logic [S_LINE-1:0] data_q  [N_WAYS][SETS];
    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   tg;
    logic [S_OFFSET-3:0] word;
    logic [WW-1:0] hit_way, inv_way, plru_way, victim_sel, victim_q, victim_n;
    logic hit, any_inv, req, miss, fill, miss_q;
    logic [31:0] hit_q, miss_cnt_q;
    logic unused;
    assign idx  = mem_addr[S_OFFSET +: S_INDEX];
    assign tg   = mem_addr[31 -: S_TAG];
    assign word = mem_addr[S_OFFSET-1:2];
    assign unused = ^mem_addr[1:0];
    // Descending scan leaves the lowest-index matching / invalid way selected.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = N_WAYS-1; w >= 0; w--) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tg) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[w][idx]) begin
                any_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
    end
    assign req        = mem_read | mem_write;
    assign mem_resp   = state == CHECK_TAG && req && hit;
    assign miss       = state == CHECK_TAG && req && !hit;
    assign fill       = state == ALLOCATE && pmem_resp;
    assign victim_sel = any_inv ? inv_way : plru_way;
    assign victim_n   = state == CHECK_TAG ? victim_sel : victim_q;
    assign mem_rdata  = data_q[hit_way][idx][{word, 5'b0} +: 32];
    assign hit_count  = hit_q;
    assign miss_count = miss_cnt_q;
    always_comb begin
        state_n = state;
        case (state)
            CHECK_TAG:  if (miss) state_n = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) ? WRITE_BACK : ALLOCATE;
            WRITE_BACK: if (pmem_resp) state_n = ALLOCATE;
            ALLOCATE:   if (pmem_resp) state_n = CHECK_TAG;
            default:    state_n = CHECK_TAG;
        endcase
    end
    // Memory-side outputs are registered from the next state so they deassert the cycle after pmem_resp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CHECK_TAG;
            victim_q   <= '0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
        end else begin
            state      <= state_n;
            victim_q   <= victim_n;
            pmem_read  <= state_n == ALLOCATE;
            pmem_write <= state_n == WRITE_BACK;
            pmem_addr  <= state_n == WRITE_BACK ? {tag_q[victim_n][idx], idx, {S_OFFSET{1'b0}}} :
                          state_n == ALLOCATE   ? {mem_addr[31:S_OFFSET], {S_OFFSET{1'b0}}} : '0;
        end
    end
    // miss_q marks the request whose replay hit after a fill must not be counted again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < N_WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                end
            miss_q     <= 1'b0;
            hit_q      <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (mem_resp && mem_write) dirty_q[hit_way][idx] <= 1'b1;
            if (state == WRITE_BACK && pmem_resp) dirty_q[victim_q][idx] <= 1'b0;
            if (fill) begin
                valid_q[victim_q][idx] <= 1'b1;
                tag_q[victim_q][idx]   <= tg;
                dirty_q[victim_q][idx] <= 1'b0;
            end
            miss_q     <= miss | (miss_q & ~mem_resp);
            hit_q      <= count_clear ? '0 : (mem_resp && !miss_q && ~&hit_q) ? hit_q + 32'd1 : hit_q;
            miss_cnt_q <= count_clear ? '0 : (miss && ~&miss_cnt_q) ? miss_cnt_q + 32'd1 : miss_cnt_q;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_resp && mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable[b]) data_q[hit_way][idx][{word, 2'(b), 3'b000} +: 8] <= mem_wdata[8*b +: 8];
        if (fill) data_q[victim_q][idx] <= pmem_rdata;
        if (state == CHECK_TAG && state_n == WRITE_BACK) pmem_wdata <= data_q[victim_sel][idx];
    end
    nway_wb_cache_plru_tree #(.S_INDEX(S_INDEX), .N_WAYS(N_WAYS)) u_plru (
        .clk        (clk),
        .reset      (reset),
        .index      (idx),
        .touch      (mem_resp),
        .touch_way  (hit_way),
        .victim_way (plru_way)
    );
endmodule

// File: tb/tb_nway_wb_cache.sv
// tb_nway_wb_cache: directed self-checking bench for nway_wb_cache with a line-wide memory model
`timescale 1ns/1ps
module tb_nway_wb_cache;
    logic clk = 1'b0, reset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pmem_addr, hit_count, miss_count;
    logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp, count_clear;
    logic [3:0] mem_byte_enable;
    logic [255:0] pmem_wdata, pmem_rdata;
    int n_assert = 0, n_fail = 0;
    int rd_cnt = 0, wr_cnt = 0, seq = 0, wb_seq = 0, rd_seq = 0, cnt = 0;
    logic [31:0] rd_addr, wb_addr;
    logic [255:0] wb_data;
    logic [255:0] mem [logic [31:0]];
    logic [31:0] rd;
    int lat, r0, w0;

    nway_wb_cache dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count),
        .count_clear(count_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_for(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a == 32'h40 ? {8{32'hA5A5_A5A5}} : {8{a ^ 32'h5A5A_0000}};
    endfunction

    // Memory responder: two-cycle latency, stores written-back lines.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt == 2) begin
                    cnt = 0;
                    pmem_resp = 1'b1;
                    seq++;
                    if (pmem_write) begin
                        mem[pmem_addr] = pmem_wdata;
                        wr_cnt++;
                        wb_addr = pmem_addr;
                        wb_data = pmem_wdata;
                        wb_seq = seq;
                    end else begin
                        pmem_rdata = line_for(pmem_addr);
                        rd_cnt++;
                        rd_addr = pmem_addr;
                        rd_seq = seq;
                    end
                end
            end
            check("never_both", {255'b0, pmem_read & pmem_write}, 256'd0);
        end
    end

    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rdat, output int l);
        @(negedge clk);
        mem_addr = a;
        mem_read = !wr;
        mem_write = wr;
        mem_wdata = wd;
        mem_byte_enable = be;
        l = 0;
        #1;
        while (!mem_resp && l < 100) begin
            @(negedge clk);
            #1;
            l++;
        end
        check("resp_seen", {255'b0, mem_resp}, 256'd1);
        rdat = mem_rdata;
        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0; mem_byte_enable = '0; count_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_resp", {255'b0, mem_resp}, 256'd0);
        check("rst_pmem_read", {255'b0, pmem_read}, 256'd0);
        check("rst_pmem_write", {255'b0, pmem_write}, 256'd0);
        check("rst_pmem_addr", {224'b0, pmem_addr}, 256'd0);
        check("rst_hits", {224'b0, hit_count}, 256'd0);
        check("rst_misses", {224'b0, miss_count}, 256'd0);
        reset = 1'b0;

        // clean read miss then hit
        access(32'h40, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t1_rdata", {224'b0, rd}, {224'b0, 32'hA5A5_A5A5});
        check("t1_lat", 256'(lat), 256'd3);
        check("t1_pmem_addr", {224'b0, rd_addr}, {224'b0, 32'h40});
        check("t1_misses", {224'b0, miss_count}, 256'd1);
        check("t1_hits", {224'b0, hit_count}, 256'd0);
        access(32'h40, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t1_hit_lat", 256'(lat), 256'd0);
        check("t1_hit_rdata", {224'b0, rd}, {224'b0, 32'hA5A5_A5A5});
        check("t1_hits2", {224'b0, hit_count}, 256'd1);

        // byte-lane write hit
        access(32'h44, 1'b1, 32'hDEAD_BEEF, 4'b0011, rd, lat);
        check("t2_wr_lat", 256'(lat), 256'd0);
        access(32'h44, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t2_merge", {224'b0, rd}, {224'b0, 32'hA5A5_BEEF});
        access(32'h40, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t2_other_word", {224'b0, rd}, {224'b0, 32'hA5A5_A5A5});
        check("t2_no_fill", 256'(rd_cnt), 256'd1);
        check("t2_no_wb", 256'(wr_cnt), 256'd0);
        check("t2_hits", {224'b0, hit_count}, 256'd4);

        // PLRU: after touching 2,0,1 the tree points at way 3
        do_reset();
        check("t3_rst_hits", {224'b0, hit_count}, 256'd0);
        for (int t = 0; t < 4; t++) access(32'(t) << 8, 1'b0, 32'h0, 4'h0, rd, lat);
        access(32'h200, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t3_hit2", 256'(lat), 256'd0);
        access(32'h000, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t3_hit0", 256'(lat), 256'd0);
        access(32'h100, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t3_hit1", 256'(lat), 256'd0);
        r0 = rd_cnt;
        access(32'h400, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t3_new_rdata", {224'b0, rd}, {224'b0, 32'h5A5A_0400});
        check("t3_fill_addr", {224'b0, rd_addr}, {224'b0, 32'h400});
        check("t3_clean_no_wb", 256'(wr_cnt), 256'd0);
        for (int t = 0; t < 3; t++) begin
            access(32'(t) << 8, 1'b0, 32'h0, 4'h0, rd, lat);
            check("t3_kept_way", 256'(lat), 256'd0);
        end
        check("t3_no_refill", 256'(rd_cnt), 256'(r0 + 1));
        access(32'h300, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t3_evicted_way3", 256'(lat), 256'd3);
        check("t3_misses", {224'b0, miss_count}, 256'd6);
        check("t3_hits", {224'b0, hit_count}, 256'd6);

        // dirty victim write-back before fill
        do_reset();
        w0 = wr_cnt;
        access(32'h0, 1'b1, 32'h1122_3344, 4'b1111, rd, lat);
        check("t4_wr_miss_lat", 256'(lat), 256'd3);
        for (int t = 1; t < 4; t++) access(32'(t) << 8, 1'b0, 32'h0, 4'h0, rd, lat);
        access(32'h400, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t4_dirty_lat", 256'(lat), 256'd6);
        check("t4_wb_count", 256'(wr_cnt), 256'(w0 + 1));
        check("t4_wb_addr", {224'b0, wb_addr}, 256'd0);
        check("t4_wb_data", wb_data, {{7{32'h5A5A_0000}}, 32'h1122_3344});
        check("t4_wb_first", {255'b0, wb_seq < rd_seq}, 256'd1);
        check("t4_rdata", {224'b0, rd}, {224'b0, 32'h5A5A_0400});
        access(32'h0, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t4_refetch", {224'b0, rd}, {224'b0, 32'h1122_3344});
        check("t4_no_extra_wb", 256'(wr_cnt), 256'(w0 + 1));

        // reset while allocating
        do_reset();
        r0 = rd_cnt;
        @(negedge clk);
        mem_addr = 32'h80;
        mem_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (pmem_read) break;
            @(negedge clk);
        end
        check("t5_alloc_started", {255'b0, pmem_read}, 256'd1);
        reset = 1'b1;
        #1;
        check("t5_abort_read", {255'b0, pmem_read}, 256'd0);
        check("t5_abort_addr", {224'b0, pmem_addr}, 256'd0);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("t5_abandoned", 256'(rd_cnt), 256'(r0));
        access(32'h80, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t5_miss_again", 256'(lat), 256'd3);
        check("t5_rdata", {224'b0, rd}, {224'b0, 32'h5A5A_0080});
        check("t5_misses", {224'b0, miss_count}, 256'd1);

        // counter clear priority and saturation
        @(negedge clk);
        mem_addr = 32'h80;
        mem_read = 1'b1;
        count_clear = 1'b1;
        #1;
        check("t6_hit_with_clear", {255'b0, mem_resp}, 256'd1);
        @(negedge clk);
        mem_read = 1'b0;
        count_clear = 1'b0;
        #1;
        check("t6_clr_hits", {224'b0, hit_count}, 256'd0);
        check("t6_clr_misses", {224'b0, miss_count}, 256'd0);
        @(negedge clk);
        force dut.hit_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_q;
        access(32'h80, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t6_sat_lat", 256'(lat), 256'd0);
        check("t6_sat_hits", {224'b0, hit_count}, {224'b0, 32'hFFFF_FFFF});
        access(32'h180, 1'b0, 32'h0, 4'h0, rd, lat);
        check("t6_miss_after_sat", {224'b0, miss_count}, 256'd1);
        check("t6_hits_still_sat", {224'b0, hit_count}, {224'b0, 32'hFFFF_FFFF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
